except_ctrl: RTL

Sequential exception/interrupt controller for the MM stage of the MIPS datapath. It resolves prioritised exception causes for the instruction in MM and synchronises a parametrised number of hardware interrupt lines. It owns the EXL, EPC, BD, ExcCode and BadVAddr state, handles ERET redirection, and drives a multi-cycle pipeline flush.

---
 rtl/except_ctrl_if.sv | 52 +++++
 rtl/except_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/except_ctrl_if.sv
// MM-stage exception controller bundle: instruction/cause inputs, CP0 inputs,
// redirect outputs and CP0 state outputs.
interface except_ctrl_if #(
    parameter int HW_INTR_W = 6
);
    logic                   mm_valid;
    logic                   mm_stall;
    logic                   slot;
    logic [31:0]            pc;
    logic                   ibus_adel;
    logic [31:0]            ibus_addr;
    logic                   dbus_adel;
    logic                   dbus_ades;
    logic [31:0]            dbus_addr;
    logic                   sy;
    logic                   bp;
    logic                   ri;
    logic                   ov;
    logic                   eret;
    logic [HW_INTR_W-1:0]   hw_intr;
    logic [1:0]             sw_intr;
    logic [HW_INTR_W+1:0]   intr_mask;
    logic                   status_ie;
    logic                   epc_we;
    logic [31:0]            epc_wdata;

    logic                   except;
    logic [31:0]            except_addr;
    logic                   flush;
    logic                   cp0_exl;
    logic                   cp0_bd;
    logic [4:0]             cp0_exc;
    logic [HW_INTR_W+1:0]   cp0_ip;
    logic [31:0]            cp0_epc;
    logic [31:0]            cp0_bva;

    modport master (
        output mm_valid, mm_stall, slot, pc, ibus_adel, ibus_addr,
               dbus_adel, dbus_ades, dbus_addr, sy, bp, ri, ov, eret,
               hw_intr, sw_intr, intr_mask, status_ie, epc_we, epc_wdata,
        input  except, except_addr, flush, cp0_exl, cp0_bd, cp0_exc,
               cp0_ip, cp0_epc, cp0_bva
    );

    modport slave (
        input  mm_valid, mm_stall, slot, pc, ibus_adel, ibus_addr,
               dbus_adel, dbus_ades, dbus_addr, sy, bp, ri, ov, eret,
               hw_intr, sw_intr, intr_mask, status_ie, epc_we, epc_wdata,
        output except, except_addr, flush, cp0_exl, cp0_bd, cp0_exc,
               cp0_ip, cp0_epc, cp0_bva
    );
endinterface

// File: rtl/except_ctrl.sv
// MM-stage exception/interrupt controller: prioritised cause resolution,
// interrupt synchronisation, EXL/EPC/BD/ExcCode/BadVAddr state, ERET and flush.
module except_ctrl #(
    parameter int          HW_INTR_W   = 6,
    parameter logic [31:0] VEC_ADDR    = 32'hbfc00380,
    parameter int          SYNC_STAGES = 2,
    parameter int          FLUSH_CYC   = 1
) (
    input  logic       clk,
    input  logic       resetn,
    except_ctrl_if.slave ctrl
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_IBUS = 2'd1,
        BVA_DBUS = 2'd2
    } bva_src_t;

    logic [SYNC_STAGES-1:0][HW_INTR_W-1:0] sync_q;
    logic [HW_INTR_W+1:0] ip;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 exl_q;
    logic                 bd_q;
    logic [4:0]           exc_q;
    logic [31:0]          epc_q;
    logic [31:0]          bva_q;

    logic                 int_req;
    logic                 commit;
    logic                 any_cause;
    logic [4:0]           cause_code;
    bva_src_t             bva_src;
    logic                 take;
    logic                 do_eret;
    logic                 redirect;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ctrl.hw_intr};
        end
    end

    assign ip      = {sync_q[SYNC_STAGES-1], ctrl.sw_intr};
    assign int_req = (|(ip & ctrl.intr_mask)) & ctrl.status_ie & ~exl_q;
    assign commit  = ctrl.mm_valid & ~ctrl.mm_stall & (flush_cnt == '0);

    // Interrupt is treated as the highest-priority cause of the MM instruction.
    always_comb begin
        any_cause  = 1'b1;
        cause_code = 5'd0;
        bva_src    = BVA_NONE;
        if (int_req) begin
            cause_code = 5'd0;
        end else if (ctrl.ibus_adel) begin
            cause_code = 5'd4;
            bva_src    = BVA_IBUS;
        end else if (ctrl.ri) begin
            cause_code = 5'd10;
        end else if (ctrl.ov) begin
            cause_code = 5'd12;
        end else if (ctrl.bp) begin
            cause_code = 5'd9;
        end else if (ctrl.sy) begin
            cause_code = 5'd8;
        end else if (ctrl.dbus_adel) begin
            cause_code = 5'd4;
            bva_src    = BVA_DBUS;
        end else if (ctrl.dbus_ades) begin
            cause_code = 5'd5;
            bva_src    = BVA_DBUS;
        end else begin
            any_cause  = 1'b0;
        end
    end

    assign take     = commit & any_cause;
    assign do_eret  = commit & ctrl.eret & ~any_cause;
    assign redirect = take | do_eret;

    // Outputs are forced low while reset is held so flush drops immediately.
    assign ctrl.except      = resetn & redirect;
    assign ctrl.flush       = resetn & (redirect | (flush_cnt != '0));
    assign ctrl.except_addr = !resetn ? 32'h0 :
                              take    ? VEC_ADDR :
                              do_eret ? epc_q : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_cnt <= '0;
        end else if (redirect) begin
            flush_cnt <= CNT_LOAD;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exl_q <= 1'b0;
            bd_q  <= 1'b0;
            exc_q <= 5'd0;
            epc_q <= 32'h0;
            bva_q <= 32'h0;
        end else begin
            if (take) begin
                exc_q <= cause_code;
                exl_q <= 1'b1;
                if (!exl_q) begin
                    bd_q <= ctrl.slot;
                end
            end else if (do_eret) begin
                exl_q <= 1'b0;
            end

            // Nested exceptions keep the original return address.
            if (take && !exl_q) begin
                epc_q <= ctrl.slot ? (ctrl.pc - 32'd4) : ctrl.pc;
            end else if (ctrl.epc_we) begin
                epc_q <= ctrl.epc_wdata;
            end

            if (take) begin
                case (bva_src)
                    BVA_IBUS: bva_q <= ctrl.ibus_addr;
                    BVA_DBUS: bva_q <= ctrl.dbus_addr;
                    default:  bva_q <= bva_q;
                endcase
            end
        end
    end

    assign ctrl.cp0_exl = exl_q;
    assign ctrl.cp0_bd  = bd_q;
    assign ctrl.cp0_exc = exc_q;
    assign ctrl.cp0_ip  = ip;
    assign ctrl.cp0_epc = epc_q;
    assign ctrl.cp0_bva = bva_q;

endmodule
